bt_pipe_in_fifo: RTL and testbench

Parametrised receive buffer behind an okBTPipeIn endpoint, on the host-interface clock domain.
- Packs incoming 16-bit pipe words into PACK-wide entries and stores them in a DEPTH-entry FIFO.
- Drives ep_ready so the host starts a block transfer only when a full block of space is free.
- Presents a show-ahead read port to downstream sequencer logic. Successor to the bare pipe-in hookup: adds block throttling, width packing, flush and error flags.

---
 rtl/bt_pipe_in_fifo_pkg.sv | 20 ++
 rtl/bt_pipe_in_fifo_if.sv | 35 +++
 rtl/bt_pipe_in_fifo_ram.sv | 29 ++
 rtl/bt_pipe_in_fifo.sv | 166 ++++++++++++++++
 tb/tb_bt_pipe_in_fifo.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/bt_pipe_in_fifo_pkg.sv
// Shared types, defaults and helpers for the okBTPipeIn receive buffer.
// Optional block counter is enabled by defining BT_FIFO_BLKCNT_EN.
package bt_fifo_pkg;

   localparam int unsigned DEF_PACK        = 2;
   localparam int unsigned DEF_DEPTH       = 1024;
   localparam int unsigned DEF_BLOCK_WORDS = 256;

   // Widths for the default configuration; instances derive their own
   localparam int unsigned AW      = $clog2(DEF_DEPTH);
   localparam int unsigned ENTRY_W = 16 * DEF_PACK;

   typedef logic [ENTRY_W-1:0] entry_t;

   // Only 1, 2 or 4 pipe words may be packed into one entry
   function automatic bit pack_legal(input int unsigned pack);
      return (pack == 1) || (pack == 2) || (pack == 4);
   endfunction

endpackage

// File: rtl/bt_pipe_in_fifo_if.sv
// Pipe-in endpoint, control and read-port bundle for bt_pipe_in_fifo.
// Optional block counter is enabled by defining BT_FIFO_BLKCNT_EN.
interface bt_pipe_in_fifo_if
   import bt_fifo_pkg::*;
#(
   parameter int unsigned ENTRY_W = bt_fifo_pkg::ENTRY_W,
   parameter int unsigned AW      = bt_fifo_pkg::AW
);

   logic               ep_write;
   logic               ep_blockstrobe;
   logic [15:0]        ep_dataout;
   logic               ep_ready;
   logic               clr;
   logic               rd_en;
   logic               rd_valid;
   logic [ENTRY_W-1:0] rd_data;
   logic [AW:0]        level;
   logic               overflow;
   logic               align_err;
   logic [15:0]        blk_count;

   // Host endpoint and downstream consumer side
   modport master (
      output ep_write, ep_blockstrobe, ep_dataout, clr, rd_en,
      input  ep_ready, rd_valid, rd_data, level, overflow, align_err, blk_count
   );

   // FIFO side
   modport slave (
      input  ep_write, ep_blockstrobe, ep_dataout, clr, rd_en,
      output ep_ready, rd_valid, rd_data, level, overflow, align_err, blk_count
   );

endinterface

// File: rtl/bt_pipe_in_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Optional block counter is enabled by defining BT_FIFO_BLKCNT_EN.
module bt_fifo_ram
   import bt_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned AW    = bt_fifo_pkg::AW,
   parameter int unsigned W     = ENTRY_W
) (
   input  logic         clk,
   input  logic         we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   // Write port: store entry on the rising edge
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/bt_pipe_in_fifo.sv
// okBTPipeIn receive buffer: packs 16-bit pipe words into PACK-wide
// entries, stores them in a DEPTH-entry FIFO and throttles the host by block.
// Optional block counter is enabled by defining BT_FIFO_BLKCNT_EN.
module bt_pipe_in_fifo
   import bt_fifo_pkg::*;
#(
   parameter int unsigned PACK        = DEF_PACK,
   parameter int unsigned DEPTH       = DEF_DEPTH,
   parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS
) (
   input  logic               ti_clk,
   input  logic               reset_b,
   bt_pipe_in_fifo_if.slave   bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned ENT_W = 16 * PACK;
   localparam int unsigned PCW   = (PACK > 1) ? $clog2(PACK) : 1;
   // Readiness straight after a flush: the whole FIFO is free
   localparam bit CLR_READY = (DEPTH * PACK >= BLOCK_WORDS);

   if (!pack_legal(PACK)) begin : g_bad_pack
      $error("bt_pipe_in_fifo: PACK must be 1, 2 or 4");
   end

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   level;
   logic [PCW-1:0]   pack_cnt;
   logic [ENT_W-1:0] pack_buf;
   logic             ep_ready_r;
   logic             overflow_r;
   logic             align_r;

   logic [PCW-1:0]   pc_eff;
   logic [PCW-1:0]   pack_cnt_next;
   logic [ENT_W-1:0] entry_now;
   logic             align_set;
   logic             push_req;
   logic             push;
   logic             pop;
   logic             drop;
   logic             full;
   logic [PTR_W:0]   level_next;
   logic             ready_next;
   logic             ram_we;
   logic [ENT_W-1:0] ram_rdata;

   // Packing, push/pop decisions and next-state readiness
   always_comb begin
      align_set = bus.ep_blockstrobe && (pack_cnt != '0);
      // A block strobe discards any partial pack before the same-cycle word
      pc_eff    = bus.ep_blockstrobe ? '0 : pack_cnt;

      entry_now = pack_buf;
      for (int unsigned s = 0; s < PACK; s++) begin
         if (pc_eff == PCW'(s)) begin
            entry_now[s*16 +: 16] = bus.ep_dataout;
         end
      end

      push_req = bus.ep_write && (pc_eff == PCW'(PACK - 1));
      full     = (level == (PTR_W+1)'(DEPTH));
      pop      = bus.rd_en && (level != '0);
      push     = push_req && (!full || pop);
      drop     = push_req && full && !pop;

      pack_cnt_next = pc_eff;
      if (bus.ep_write) begin
         pack_cnt_next = push_req ? '0 : pc_eff + PCW'(1);
      end

      level_next = level;
      if (push && !pop) begin
         level_next = level + 1'b1;
      end else if (pop && !push) begin
         level_next = level - 1'b1;
      end

      // free_words >= BLOCK_WORDS, rearranged so the subtraction cannot wrap
      ready_next = ((32'(DEPTH) - 32'(level_next)) * 32'(PACK))
                   >= (32'(BLOCK_WORDS) + 32'(pack_cnt_next));

      ram_we = push && reset_b && !bus.clr;
   end

   // Pointer, level, pack and flag state with reset and flush
   always_ff @(posedge ti_clk) begin
      if (!reset_b) begin
         head       <= '0;
         tail       <= '0;
         level      <= '0;
         pack_cnt   <= '0;
         pack_buf   <= '0;
         ep_ready_r <= 1'b0;
         overflow_r <= 1'b0;
         align_r    <= 1'b0;
      end else if (bus.clr) begin
         head       <= '0;
         tail       <= '0;
         level      <= '0;
         pack_cnt   <= '0;
         pack_buf   <= '0;
         ep_ready_r <= CLR_READY;
         overflow_r <= 1'b0;
         align_r    <= 1'b0;
      end else begin
         if (push) begin
            tail <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         if (bus.ep_write) begin
            pack_buf <= entry_now;
         end
         if (drop) begin
            overflow_r <= 1'b1;
         end
         if (align_set) begin
            align_r <= 1'b1;
         end
         level      <= level_next;
         pack_cnt   <= pack_cnt_next;
         ep_ready_r <= ready_next;
      end
   end

`ifdef BT_FIFO_BLKCNT_EN
   logic [15:0] blk_cnt_r;

   // Count block strobes, wrapping at 16 bits
   always_ff @(posedge ti_clk) begin
      if (!reset_b || bus.clr) begin
         blk_cnt_r <= '0;
      end else if (bus.ep_blockstrobe) begin
         blk_cnt_r <= blk_cnt_r + 16'd1;
      end
   end

   assign bus.blk_count = blk_cnt_r;
`else
   assign bus.blk_count = '0;
`endif

   bt_fifo_ram #(
      .DEPTH (DEPTH),
      .AW    (PTR_W),
      .W     (ENT_W)
   ) u_ram (
      .clk   (ti_clk),
      .we    (ram_we),
      .waddr (tail),
      .wdata (entry_now),
      .raddr (head),
      .rdata (ram_rdata)
   );

   assign bus.rd_valid  = (level != '0);
   assign bus.rd_data   = bus.rd_valid ? ram_rdata : '0;
   assign bus.level     = level;
   assign bus.ep_ready  = ep_ready_r;
   assign bus.overflow  = overflow_r;
   assign bus.align_err = align_r;

endmodule

// File: tb/tb_bt_pipe_in_fifo.sv
// Scoreboard bench for bt_pipe_in_fifo with PACK=2, DEPTH=8, BLOCK_WORDS=4.
// Honours BT_FIFO_BLKCNT_EN for the block counter checks.
module tb_bt_pipe_in_fifo;

   localparam int unsigned PACK  = 2;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned BW    = 4;
   localparam int unsigned AW    = 3;
   localparam int unsigned EW    = 32;

   logic clk = 1'b0;
   logic reset_b;
   always #5 clk = ~clk;

   bt_pipe_in_fifo_if #(.ENTRY_W(EW), .AW(AW)) bus ();

   bt_pipe_in_fifo #(
      .PACK        (PACK),
      .DEPTH       (DEPTH),
      .BLOCK_WORDS (BW)
   ) dut (
      .ti_clk  (clk),
      .reset_b (reset_b),
      .bus     (bus)
   );

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_q [$];
   logic [31:0] mon_exp;
   logic [15:0] strobes = '0;

   // Monitor: every accepted pop is compared against the scoreboard head
   always @(negedge clk) begin
      if (reset_b && !bus.clr && bus.rd_en && bus.rd_valid) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL pop_data: got %h, expected nothing (scoreboard empty)", bus.rd_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (bus.rd_data !== mon_exp) begin
               miscompares++;
               $display("FAIL pop_data: got %h, expected %h", bus.rd_data, mon_exp);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [15:0] d);
      bus.ep_write   = 1'b1;
      bus.ep_dataout = d;
      tick();
      bus.ep_write   = 1'b0;
   endtask

   // Write n complete entries; low word first
   task automatic fill(input int n, input logic [15:0] base, input bit expect_stored);
      logic [15:0] lo;
      logic [15:0] hi;
      for (int i = 0; i < n; i++) begin
         lo = base + 16'(2*i);
         hi = base + 16'(2*i + 1);
         put(lo);
         put(hi);
         if (expect_stored) exp_q.push_back({hi, lo});
      end
   endtask

   task automatic strobe();
      bus.ep_blockstrobe = 1'b1;
      tick();
      bus.ep_blockstrobe = 1'b0;
      strobes = strobes + 16'd1;
   endtask

   task automatic drain();
      bus.rd_en = 1'b1;
      for (int i = 0; i < int'(DEPTH) + 4 && bus.rd_valid; i++) tick();
      bus.rd_en = 1'b0;
      chk("drained_level", 32'(bus.level), 32'd0);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic flush();
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      exp_q.delete();
      strobes = '0;
   endtask

   function automatic logic [15:0] exp_blk();
`ifdef BT_FIFO_BLKCNT_EN
      return strobes;
`else
      return 16'd0;
`endif
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ep_write       = 1'b0;
      bus.ep_blockstrobe = 1'b0;
      bus.ep_dataout     = '0;
      bus.clr            = 1'b0;
      bus.rd_en          = 1'b0;
      reset_b            = 1'b0;
      tick();
      tick();
      chk("rst_level", 32'(bus.level), 32'd0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("rst_rd_data", bus.rd_data, 32'h0);
      chk("rst_ep_ready", 32'(bus.ep_ready), 32'd0);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      chk("rst_align_err", 32'(bus.align_err), 32'd0);
      chk("rst_blk_count", 32'(bus.blk_count), 32'd0);
      reset_b = 1'b1;
      tick();
      chk("ready_after_release", 32'(bus.ep_ready), 32'd1);

      // Basic packing
      put(16'h1111); put(16'h2222); put(16'h3333); put(16'h4444);
      exp_q.push_back(32'h22221111);
      exp_q.push_back(32'h44443333);
      chk("pack_level", 32'(bus.level), 32'd2);
      chk("pack_ready", 32'(bus.ep_ready), 32'd1);
      drain();

      // Block throttling: 6 entries leave exactly one block free
      fill(6, 16'h1000, 1'b1);
      chk("lvl6_level", 32'(bus.level), 32'd6);
      chk("lvl6_ready", 32'(bus.ep_ready), 32'd1);
      put(16'h100C); put(16'h100D);
      exp_q.push_back(32'h100D100C);
      chk("lvl7_level", 32'(bus.level), 32'd7);
      chk("lvl7_ready", 32'(bus.ep_ready), 32'd0);

      // Fill to full then overflow
      put(16'h100E); put(16'h100F);
      exp_q.push_back(32'h100F100E);
      chk("full_level", 32'(bus.level), 32'd8);
      put(16'h2000); put(16'h2001);
      chk("ovf_level", 32'(bus.level), 32'd8);
      chk("ovf_flag", 32'(bus.overflow), 32'd1);
      chk("ovf_ready", 32'(bus.ep_ready), 32'd0);
      drain();
      flush();
      chk("flush_overflow", 32'(bus.overflow), 32'd0);

      // Full with pack completing on a pop cycle: both succeed
      fill(8, 16'h3000, 1'b1);
      chk("full2_level", 32'(bus.level), 32'd8);
      put(16'h4000);
      bus.rd_en = 1'b1;
      put(16'h4001);
      bus.rd_en = 1'b0;
      exp_q.push_back(32'h40014000);
      chk("pushpop_level", 32'(bus.level), 32'd8);
      chk("pushpop_overflow", 32'(bus.overflow), 32'd0);
      drain();

      // Block strobe with partial pack pending
      put(16'hAAAA);
      strobe();
      put(16'hBBBB); put(16'hCCCC);
      exp_q.push_back(32'hCCCCBBBB);
      chk("align_flag", 32'(bus.align_err), 32'd1);
      chk("align_level", 32'(bus.level), 32'd1);
      drain();

      // Strobe and write in the same cycle: the word starts a new pack
      put(16'hDDDD);
      bus.ep_blockstrobe = 1'b1;
      put(16'hEEEE);
      bus.ep_blockstrobe = 1'b0;
      strobes = strobes + 16'd1;
      put(16'hFFFF);
      exp_q.push_back(32'hFFFFEEEE);
      chk("strobe_write_level", 32'(bus.level), 32'd1);
      drain();
      chk("blk_count_2", 32'(bus.blk_count), 32'(exp_blk()));

      // Flush from level 5
      fill(5, 16'h5000, 1'b0);
      chk("pre_clr_level", 32'(bus.level), 32'd5);
      flush();
      chk("clr_level", 32'(bus.level), 32'd0);
      chk("clr_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("clr_overflow", 32'(bus.overflow), 32'd0);
      chk("clr_align_err", 32'(bus.align_err), 32'd0);
      chk("clr_ready", 32'(bus.ep_ready), 32'd1);
      chk("clr_blk_count", 32'(bus.blk_count), 32'd0);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      chk("empty_pop_level", 32'(bus.level), 32'd0);
      chk("empty_pop_overflow", 32'(bus.overflow), 32'd0);

`ifdef BT_FIFO_BLKCNT_EN
      bus.ep_blockstrobe = 1'b1;
      repeat (65537) tick();
      bus.ep_blockstrobe = 1'b0;
      strobes = 16'd1;
      chk("blk_count_wrap", 32'(bus.blk_count), 32'd1);
`else
      strobe();
      strobe();
      chk("blk_count_tied", 32'(bus.blk_count), 32'(exp_blk()));
`endif

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
